// File: rtl/ltc2500_sample_buffer_if.sv
// Read-side stream of the LTC2500 sample buffer: FWFT head with valid/ready handshake.
// The tag bit marks the head's source: 0 = raw conversion, 1 = filtered result.
interface ltc2500_sample_buffer_if;
  logic        valid;
  logic [31:0] data;
  logic        tag;
  logic        ready;

  modport master (
    output valid,
    output data,
    output tag,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  tag,
    output ready
  );
endinterface

// File: rtl/ltc2500_sample_buffer.sv
// Merges LTC2500 raw and filtered result strobes into one tagged first-word-fall-through FIFO.
// Samples that cannot be stored are counted in a sticky, saturating drop counter.
module ltc2500_sample_buffer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    done_i,
  input  logic [19:0]             data_i,
  input  logic                    done_filt_i,
  input  logic [31:0]             data_filt_i,
  ltc2500_sample_buffer_if.master m_if,
  output logic [Aw:0]             level_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_count_o,
  input  logic                    clr_ovf_i
);

  localparam logic [Aw:0] LevelFull = (Aw + 1)'(Depth);

  // Entry format: {tag, data}.
  logic [32:0]   mem_q [Depth];
  logic [Aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [Aw:0]   level_q, level_d;
  logic [32:0]   pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;

  logic        cap_raw, cap_filt, full, pop;
  logic        wr_req, wr_ok, pend_drain, drop_filt, drop_raw;
  logic [32:0] raw_word, filt_word, wr_word, head;
  logic [1:0]  drop_inc;
  logic [16:0] cnt_sum;

  always_comb begin
    cap_raw   = enable_i & done_i;
    cap_filt  = enable_i & done_filt_i;
    raw_word  = {1'b0, {12{data_i[19]}}, data_i};
    filt_word = {1'b1, data_filt_i};
    full      = (level_q == LevelFull);
    pop       = (level_q != '0) & m_if.ready;

    // One write per cycle: filtered strobe, then pending raw, then a fresh raw strobe.
    wr_req     = 1'b0;
    wr_word    = '0;
    pend_drain = 1'b0;
    if (cap_filt) begin
      wr_req  = 1'b1;
      wr_word = filt_word;
    end else if (pend_valid_q) begin
      wr_req     = 1'b1;
      wr_word    = pend_q;
      pend_drain = !full;
    end else if (cap_raw) begin
      wr_req  = 1'b1;
      wr_word = raw_word;
    end
    wr_ok     = wr_req & !full;
    drop_filt = cap_filt & full;

    // A raw strobe that loses arbitration parks in pending, unless pending is still held.
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q & !pend_drain;
    drop_raw     = 1'b0;
    if (cap_raw && (cap_filt || pend_valid_q)) begin
      if (pend_valid_q && !pend_drain) begin
        drop_raw = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = raw_word;
      end
    end else if (cap_raw && full) begin
      drop_raw = 1'b1;
    end

    wr_ptr_d = wr_ptr_q + Aw'(wr_ok);
    rd_ptr_d = rd_ptr_q + Aw'(pop);
    level_d  = level_q + (Aw + 1)'(wr_ok) - (Aw + 1)'(pop);

    drop_inc = {1'b0, drop_filt} + {1'b0, drop_raw};
    cnt_sum  = {1'b0, cnt_q} + 17'(drop_inc);
    cnt_d    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    ovf_d    = ovf_q | (drop_inc != 2'd0);
    if (clr_ovf_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    m_if.valid   = (level_q != '0);
    m_if.data    = m_if.valid ? head[31:0] : 32'h0;
    m_if.tag     = m_if.valid & head[32];
    level_o      = level_q;
    overflow_o   = ovf_q;
    drop_count_o = cnt_q;
  end

endmodule

// File: tb/tb_ltc2500_sample_buffer.sv
// Directed bench for ltc2500_sample_buffer: a per-cycle vector table plus multi-cycle
// sequences covering full FIFO, drop accounting, clear priority and reset mid-traffic.
module tb_ltc2500_sample_buffer;

  logic        clk = 1'b0;
  logic        reset, enable, done, done_filt, clr_ovf;
  logic [19:0] data;
  logic [31:0] data_filt;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  ltc2500_sample_buffer_if bus ();

  ltc2500_sample_buffer #(
    .Depth (16),
    .Aw    (4)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .done_i       (done),
    .data_i       (data),
    .done_filt_i  (done_filt),
    .data_filt_i  (data_filt),
    .m_if         (bus),
    .level_o      (level),
    .overflow_o   (overflow),
    .drop_count_o (drop_count),
    .clr_ovf_i    (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, dn;
    logic [19:0] d;
    logic        df;
    logic [31:0] dfd;
    logic        rdy, clr;
    logic        ev;
    logic [31:0] edata;
    logic        etag;
    logic [4:0]  elvl;
    logic        eovf;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [31:0] edata,
                           input logic etag, input logic [4:0] elvl, input logic eovf,
                           input logic [15:0] ecnt);
    chk({name, ".valid"}, 32'(bus.valid), 32'(ev));
    chk({name, ".data"}, bus.data, edata);
    chk({name, ".tag"}, 32'(bus.tag), 32'(etag));
    chk({name, ".level"}, 32'(level), 32'(elvl));
    chk({name, ".overflow"}, 32'(overflow), 32'(eovf));
    chk({name, ".drop_count"}, 32'(drop_count), 32'(ecnt));
  endtask

  task automatic drive(input logic rst, input logic en, input logic dn, input logic [19:0] d,
                       input logic df, input logic [31:0] dfd, input logic rdy,
                       input logic clr);
    reset     = rst;
    enable    = en;
    done      = dn;
    data      = d;
    done_filt = df;
    data_filt = dfd;
    bus.ready = rdy;
    clr_ovf   = clr;
  endtask

  // Inputs are changed 1 time unit after a rising edge and outputs sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    //           rst en dn d         df dfd            rdy clr | v data          tag lvl ovf cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 20'h0,     1'b0, 32'h0,        1'b0, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 20'h80001, 1'b0, 32'h0,        1'b0, 1'b0,
                 1'b1, 32'hFFF80001, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 20'h00005, 1'b1, 32'hABCD1234, 1'b1, 1'b0,
                 1'b1, 32'hABCD1234, 1'b1, 5'd1, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'h00000005, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 20'h12345, 1'b0, 32'h0,        1'b0, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 20'h0,     1'b1, 32'hDEADBEEF, 1'b0, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b1, 32'h12345678, 1'b0, 1'b0,
                 1'b1, 32'h12345678, 1'b1, 5'd1, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 20'h7FFFF, 1'b0, 32'h0,        1'b0, 1'b0,
                 1'b1, 32'h12345678, 1'b1, 5'd2, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'h0007FFFF, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 20'h00001, 1'b1, 32'h11111111, 1'b0, 1'b0,
                 1'b1, 32'h11111111, 1'b1, 5'd1, 1'b0, 16'd0};
    // Pending still held (filt wins the write), so the second raw is dropped.
    vecs[13] = '{1'b0, 1'b1, 1'b1, 20'h00002, 1'b1, 32'h22222222, 1'b0, 1'b0,
                 1'b1, 32'h11111111, 1'b1, 5'd2, 1'b1, 16'd1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b0, 1'b0,
                 1'b1, 32'h11111111, 1'b1, 5'd3, 1'b1, 16'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'h22222222, 1'b1, 5'd2, 1'b1, 16'd1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'h00000001, 1'b0, 5'd1, 1'b1, 16'd1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b1, 16'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b0, 1'b1,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 20'h00003, 1'b1, 32'h33333333, 1'b0, 1'b0,
                 1'b1, 32'h33333333, 1'b1, 5'd1, 1'b0, 16'd0};
    // Pending drains while a new raw refills it: no drop.
    vecs[20] = '{1'b0, 1'b1, 1'b1, 20'hFFFFE, 1'b0, 32'h0,        1'b0, 1'b0,
                 1'b1, 32'h33333333, 1'b1, 5'd2, 1'b0, 16'd0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b0, 1'b0,
                 1'b1, 32'h33333333, 1'b1, 5'd3, 1'b0, 16'd0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'h00000003, 1'b0, 5'd2, 1'b0, 16'd0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b1, 32'hFFFFFFFE, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 20'h0,     1'b0, 32'h0,        1'b1, 1'b0,
                 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 16'd0};

    step();
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].dn, vecs[i].d, vecs[i].df, vecs[i].dfd,
            vecs[i].rdy, vecs[i].clr);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].edata, vecs[i].etag,
                vecs[i].elvl, vecs[i].eovf, vecs[i].ecnt);
    end

    // Fill to 16, then three more filtered strobes are dropped.
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 32'hF0000000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    check_all("fill", 1'b1, 32'hF0000000, 1'b1, 5'd16, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    check_all("clr", 1'b1, 32'hF0000000, 1'b1, 5'd16, 1'b0, 16'd0);

    // Pop in the same cycle as a write to a full FIFO does not make room for it.
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
    step();
    check_all("full_pop", 1'b1, 32'hF0000001, 1'b1, 5'd15, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 32'hBBBBBBBB, 1'b0, 1'b0);
    step();
    check_all("refill", 1'b1, 32'hF0000001, 1'b1, 5'd16, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 32'hCCCCCCCC, 1'b0, 1'b1);
    step();
    check_all("clr_wins", 1'b1, 32'hF0000001, 1'b1, 5'd16, 1'b0, 16'd0);

    // Full: pair parks raw in pending; second pair drops filt and raw together.
    drive(1'b0, 1'b1, 1'b1, 20'h00010, 1'b1, 32'hDDDDDDDD, 1'b0, 1'b0);
    step();
    check_all("pair_full", 1'b1, 32'hF0000001, 1'b1, 5'd16, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 1'b1, 20'h00011, 1'b1, 32'hEEEEEEEE, 1'b0, 1'b0);
    step();
    check_all("double_drop", 1'b1, 32'hF0000001, 1'b1, 5'd16, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_all("pend_blocked", 1'b1, 32'hF0000002, 1'b1, 5'd15, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_all("pend_written", 1'b1, 32'hF0000002, 1'b1, 5'd16, 1'b1, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step();
    check_all("tail", 1'b1, 32'h00000010, 1'b0, 5'd1, 1'b1, 16'd3);
    step();
    check_all("drained", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 16'd3);

    // Reset with level 7 and a pending raw sample in flight.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 32'h50000000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 20'h00077, 1'b1, 32'h50000006, 1'b0, 1'b0);
    step();
    check_all("pre_reset", 1'b1, 32'h50000000, 1'b1, 5'd7, 1'b1, 16'd3);
    drive(1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_all("reset", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_all("pend_flushed", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 1'b1, 20'h00042, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_all("post_reset", 1'b1, 32'h00000042, 1'b0, 5'd1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check_all("one_beat", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_all("stay_empty", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
